cvxif_coproc_responder: RTL and testbench

- Coprocessor-side responder for the CVXIF issue interface driven by the issue stage.
- Accepts offloaded instructions with operands and transaction ID on a valid/ready handshake, and buffers them in a small FIFO.
- Executes them one at a time with a fixed multi-cycle latency.
- Returns one writeback beat per instruction (trans_id, data, we, exception) toward the execute-stage writeback ports.

---
 rtl/cvxif_coproc_responder.sv | 235 +++++++++++++++++++++++
 tb/tb_cvxif_coproc_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_coproc_responder.sv
// cvxif_coproc_responder
// ----------------------
// Coprocessor-side responder for the CVXIF issue interface. Instructions are
// accepted on a valid/ready handshake together with their operands and
// scoreboard ID. They are buffered in a small FIFO and then executed one at a
// time. Each execution takes a fixed number of cycles. Every instruction
// produces exactly one writeback beat, and beats leave in acceptance order.
//
// Optional feature macro: CVXIF_MUL_OP_EN
//   When this macro is defined, funct3=4 of custom-0 returns the low XLEN bits
//   of the unsigned product rs1*rs2. When it is undefined, funct3=4 is illegal.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                discard all buffered and in-flight work
//   x_issue_valid_i/ready_o  offload handshake
//   x_off_instr_i          instruction word
//   x_trans_id_i           scoreboard transaction ID
//   x_rs1_i, x_rs2_i       source operands
//   x_result_valid_o       one-cycle writeback strobe
//   x_result_trans_id_o    ID of the completed instruction
//   x_result_data_o        result value
//   x_result_we_o          write rd
//   x_result_ex_valid_o    illegal-instruction exception
//   x_result_ex_cause_o    exception cause
//   busy_o                 FIFO non-empty or FSM not idle

module cvxif_coproc_responder #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned LATENCY       = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     x_issue_valid_i,
  output logic                     x_issue_ready_o,
  input  logic [31:0]              x_off_instr_i,
  input  logic [TRANS_ID_BITS-1:0] x_trans_id_i,
  input  logic [XLEN-1:0]          x_rs1_i,
  input  logic [XLEN-1:0]          x_rs2_i,
  output logic                     x_result_valid_o,
  output logic [TRANS_ID_BITS-1:0] x_result_trans_id_o,
  output logic [XLEN-1:0]          x_result_data_o,
  output logic                     x_result_we_o,
  output logic                     x_result_ex_valid_o,
  output logic [XLEN-1:0]          x_result_ex_cause_o,
  output logic                     busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned PW = $clog2(XLEN + 1);
  localparam logic [6:0]  OPCODE_CUSTOM0 = 7'b0001011;

  typedef struct packed {
    logic [31:0]              instr;
    logic [TRANS_ID_BITS-1:0] id;
    logic [XLEN-1:0]          rs1;
    logic [XLEN-1:0]          rs2;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state_q, state_d;

  entry_t fifo_mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic        push, pop;

  entry_t      exec_q;
  logic [CW-1:0] cnt_q;
  logic        cnt_dec;
  logic        res_latch;

  logic [TRANS_ID_BITS-1:0] res_id_q;
  logic [XLEN-1:0]          res_data_q;
  logic                     res_we_q;
  logic                     res_ex_q;

  logic [XLEN-1:0] alu_data;
  logic            alu_legal;
  logic [PW-1:0]   pop_count;
  logic            result_valid;

  logic [6:0] exec_opcode;
  logic [2:0] exec_funct3;
  logic       unused_instr_bits;

  // The extra pointer bit distinguishes a full FIFO from an empty one once
  // the index bits have wrapped.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Ready comes from registered state only. A pop in the same cycle does not
  // free a slot early, and a handshake during a flush is dropped.
  assign x_issue_ready_o = !fifo_full;
  assign push            = x_issue_valid_i && !fifo_full && !flush_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= '{instr: x_off_instr_i, id: x_trans_id_i,
                                    rs1: x_rs1_i, rs2: x_rs2_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Next-state logic. RESP chains directly into the next EXEC when more work
  // is queued, so throughput is one result every LATENCY+1 cycles.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    cnt_dec   = 1'b0;
    res_latch = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            res_latch = 1'b1;
            state_d   = RESP;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        RESP: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      exec_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        exec_q <= fifo_mem[rd_ptr[AW-1:0]];
        cnt_q  <= CW'(LATENCY - 1);
      end else if (cnt_dec) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign exec_opcode       = exec_q.instr[6:0];
  assign exec_funct3       = exec_q.instr[14:12];
  assign unused_instr_bits = ^{exec_q.instr[31:15], exec_q.instr[11:7]};

  always_comb begin
    pop_count = '0;
    for (int i = 0; i < int'(XLEN); i++) begin
      pop_count = pop_count + PW'(exec_q.rs1[i]);
    end
  end

  always_comb begin
    alu_data  = '0;
    alu_legal = 1'b0;
    if (exec_opcode == OPCODE_CUSTOM0) begin
      case (exec_funct3)
        3'd0: begin alu_data = exec_q.rs1 + exec_q.rs2;  alu_legal = 1'b1; end
        3'd1: begin alu_data = exec_q.rs1 - exec_q.rs2;  alu_legal = 1'b1; end
        3'd2: begin alu_data = exec_q.rs1 ^ exec_q.rs2;  alu_legal = 1'b1; end
        3'd3: begin alu_data = exec_q.rs1 & ~exec_q.rs2; alu_legal = 1'b1; end
        3'd5: begin alu_data = XLEN'(pop_count);         alu_legal = 1'b1; end
`ifdef CVXIF_MUL_OP_EN
        3'd4: begin alu_data = exec_q.rs1 * exec_q.rs2;  alu_legal = 1'b1; end
`endif
        default: begin alu_data = '0; alu_legal = 1'b0; end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_id_q   <= '0;
      res_data_q <= '0;
      res_we_q   <= 1'b0;
      res_ex_q   <= 1'b0;
    end else if (res_latch) begin
      res_id_q   <= exec_q.id;
      res_data_q <= alu_data;
      res_we_q   <= alu_legal;
      res_ex_q   <= !alu_legal;
    end
  end

  // A RESP beat that coincides with a flush is suppressed. All result fields
  // read as zero whenever no beat is being driven.
  assign result_valid        = (state_q == RESP) && !flush_i;
  assign x_result_valid_o    = result_valid;
  assign x_result_trans_id_o = result_valid ? res_id_q   : '0;
  assign x_result_data_o     = result_valid ? res_data_q : '0;
  assign x_result_we_o       = result_valid && res_we_q;
  assign x_result_ex_valid_o = result_valid && res_ex_q;
  assign x_result_ex_cause_o = (result_valid && res_ex_q) ? XLEN'(2) : '0;

  assign busy_o = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_cvxif_coproc_responder.sv
// Directed testbench for cvxif_coproc_responder. It applies a table of
// single-instruction vectors and then runs hand-written sequences for the
// fill, flush, flush-during-response and reset-mid-exec cases.

module tb_cvxif_coproc_responder;

  localparam int LAT = 3;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] off_instr;
  logic [2:0]  trans_id;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        res_valid;
  logic [2:0]  res_id;
  logic [31:0] res_data;
  logic        res_we;
  logic        res_ex_valid;
  logic [31:0] res_ex_cause;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  cvxif_coproc_responder #(
    .XLEN(32), .TRANS_ID_BITS(3), .DEPTH(4), .LATENCY(LAT)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .flush_i             (flush),
    .x_issue_valid_i     (issue_valid),
    .x_issue_ready_o     (issue_ready),
    .x_off_instr_i       (off_instr),
    .x_trans_id_i        (trans_id),
    .x_rs1_i             (rs1),
    .x_rs2_i             (rs2),
    .x_result_valid_o    (res_valid),
    .x_result_trans_id_o (res_id),
    .x_result_data_o     (res_data),
    .x_result_we_o       (res_we),
    .x_result_ex_valid_o (res_ex_valid),
    .x_result_ex_cause_o (res_ex_cause),
    .busy_o              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_we;
    logic        exp_ex;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [31:0] mkInstr(input logic [2:0] f3, input logic [6:0] op);
    return {17'h0, f3, 5'd1, op};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled on the
  // falling edge. Each task starts and ends just after a rising edge.
  task automatic applyStimulus(input logic [31:0] instr, input logic [2:0] id,
                               input logic [31:0] a, input logic [31:0] b);
    issue_valid = 1'b1;
    off_instr   = instr;
    trans_id    = id;
    rs1         = a;
    rs2         = b;
  endtask

  task automatic idleInputs();
    issue_valid = 1'b0;
    off_instr   = '0;
    trans_id    = '0;
    rs1         = '0;
    rs2         = '0;
  endtask

  task automatic runVector(input int idx);
    int beats;
    int hit;
    logic bad_idle;
    beats = 0; hit = 0; bad_idle = 1'b0;
    applyStimulus(vecs[idx].instr, vecs[idx].id, vecs[idx].a, vecs[idx].b);
    @(negedge clk);
    checkOutput($sformatf("v%0d_ready", idx), {31'b0, issue_ready}, 32'd1);
    @(posedge clk); #1;
    idleInputs();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (res_valid) begin
        beats++;
        if (beats == 1) begin
          hit = k;
          checkOutput($sformatf("v%0d_id", idx),    {29'b0, res_id}, {29'b0, vecs[idx].id});
          checkOutput($sformatf("v%0d_data", idx),  res_data, vecs[idx].exp_data);
          checkOutput($sformatf("v%0d_we", idx),    {31'b0, res_we}, {31'b0, vecs[idx].exp_we});
          checkOutput($sformatf("v%0d_ex", idx),    {31'b0, res_ex_valid}, {31'b0, vecs[idx].exp_ex});
          checkOutput($sformatf("v%0d_cause", idx), res_ex_cause, vecs[idx].exp_ex ? 32'd2 : 32'd0);
        end
      end else if (res_data != 0 || res_id != 0 || res_we || res_ex_valid || res_ex_cause != 0) begin
        bad_idle = 1'b1;
      end
    end
    checkOutput($sformatf("v%0d_beats", idx), beats, 32'd1);
    checkOutput($sformatf("v%0d_latency", idx), hit, LAT + 2);
    checkOutput($sformatf("v%0d_idle_zero", idx), {31'b0, bad_idle}, 32'd0);
    @(posedge clk); #1;
  endtask

  int          beat_cyc[8];
  logic [2:0]  beat_id[8];
  logic [31:0] beat_data[8];
  int          nb;

  initial begin
    localparam logic [6:0] C0 = 7'b0001011;
    vecs[0] = '{mkInstr(3'd0, C0), 3'd3, 32'd5, 32'd7, 32'd12, 1'b1, 1'b0};
    vecs[1] = '{mkInstr(3'd1, C0), 3'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[2] = '{mkInstr(3'd5, C0), 3'd2, 32'hFFFF_FFFF, 32'd9, 32'd32, 1'b1, 1'b0};
    vecs[3] = '{mkInstr(3'd0, C0), 3'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0};
    vecs[4] = '{mkInstr(3'd2, C0), 3'd5, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hAAAA_AAAA, 1'b1, 1'b0};
    vecs[5] = '{mkInstr(3'd3, C0), 3'd7, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0000, 1'b1, 1'b0};
    vecs[6] = '{mkInstr(3'd5, C0), 3'd0, 32'h0000_00F3, 32'd0, 32'd6, 1'b1, 1'b0};
    vecs[7] = '{mkInstr(3'd0, 7'b0110011), 3'd6, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1};
    vecs[8] = '{mkInstr(3'd6, C0), 3'd2, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1};
`ifdef CVXIF_MUL_OP_EN
    vecs[9] = '{mkInstr(3'd4, C0), 3'd1, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 1'b0};
`else
    vecs[9] = '{mkInstr(3'd4, C0), 3'd1, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b1};
`endif

    rst_n = 1'b0;
    flush = 1'b0;
    idleInputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", {31'b0, issue_ready}, 32'd1);
    checkOutput("rst_valid", {31'b0, res_valid}, 32'd0);
    checkOutput("rst_busy",  {31'b0, busy}, 32'd0);
    checkOutput("rst_data",  res_data, 32'd0);
    checkOutput("rst_ex",    {31'b0, res_ex_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      runVector(i);
    end

    // Fill: id 7 occupies the executor while ids 0..3 fill all four slots.
    applyStimulus(mkInstr(3'd0, C0), 3'd7, 32'd70, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      applyStimulus(mkInstr(3'd0, C0), 3'(i), 32'(i + 100), 32'd0);
    end
    @(posedge clk); #1;
    idleInputs();
    nb = 0;
    for (int n = 5; n <= 30; n++) begin
      @(negedge clk);
      if (n == 5) checkOutput("fill_ready_full", {31'b0, issue_ready}, 32'd0);
      if (n == 6) checkOutput("fill_ready_rise", {31'b0, issue_ready}, 32'd1);
      if (res_valid && nb < 8) begin
        beat_cyc[nb]  = n;
        beat_id[nb]   = res_id;
        beat_data[nb] = res_data;
        nb++;
      end
      if (n < 30) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    checkOutput("fill_beats", nb, 32'd5);
    if (nb == 5) begin
      checkOutput("fill_first_id", {29'b0, beat_id[0]}, 32'd7);
      checkOutput("fill_first_cyc", beat_cyc[0], 32'd5);
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("fill_id%0d", i),   {29'b0, beat_id[i+1]}, 32'(i));
        checkOutput($sformatf("fill_data%0d", i), beat_data[i+1], 32'(i + 100));
        checkOutput($sformatf("fill_cyc%0d", i),  beat_cyc[i+1], 32'(9 + 4 * i));
      end
    end

    // Flush with three entries queued and one in EXEC; the handshake offered
    // in the flush cycle must be dropped.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mkInstr(3'd0, C0), 3'(i), 32'd1, 32'd1);
      @(posedge clk); #1;
    end
    applyStimulus(mkInstr(3'd0, C0), 3'd5, 32'd1, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_busy_before", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    idleInputs();
    @(negedge clk);
    checkOutput("flush_busy_after", {31'b0, busy}, 32'd0);
    checkOutput("flush_ready_after", {31'b0, issue_ready}, 32'd1);
    nb = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (res_valid) nb++;
    end
    checkOutput("flush_no_beats", nb, 32'd0);
    @(posedge clk); #1;

    // Flush landing exactly on the response cycle suppresses the beat.
    applyStimulus(mkInstr(3'd0, C0), 3'd4, 32'd2, 32'd3);
    @(posedge clk); #1;
    idleInputs();
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("resp_flush_valid", {31'b0, res_valid}, 32'd0);
    checkOutput("resp_flush_data", res_data, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    nb = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (res_valid) nb++;
    end
    checkOutput("resp_flush_no_beats", nb, 32'd0);
    checkOutput("resp_flush_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset while the instruction is in EXEC.
    applyStimulus(mkInstr(3'd0, C0), 3'd2, 32'd4, 32'd4);
    @(posedge clk); #1;
    idleInputs();
    repeat (2) @(posedge clk);
    #2;
    checkOutput("arst_busy_before", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", {31'b0, busy}, 32'd0);
    checkOutput("arst_ready", {31'b0, issue_ready}, 32'd1);
    checkOutput("arst_valid", {31'b0, res_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nb = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (res_valid) nb++;
    end
    checkOutput("arst_no_stale", nb, 32'd0);
    checkOutput("arst_busy_after", {31'b0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
